// File: rtl/sm_step_scheduler.sv
// Step-pulse sequencer: turns a target step period from the tracking loop into
// drv_step/drv_dir with a fixed pulse width, a direction setup gap and a
// slew-limited period ramp. All outputs are registered.
module sm_step_scheduler #(
  parameter int unsigned WIDTH_WORK   = 16,
  parameter int unsigned PULSE_HI     = 100,
  parameter int unsigned DIR_SETUP    = 250,
  parameter int unsigned N_MIN        = 200,
  parameter int unsigned START_PERIOD = 4000,
  parameter int unsigned ACC_STEP     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  dir_req,
  input  logic [WIDTH_WORK-1:0] period_in,
  input  logic                  period_load,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  busy,
  output logic [WIDTH_WORK-1:0] step_cnt
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DIR_SETUP  = 2'd1;
  localparam logic [1:0] ST_PULSE_HIGH = 2'd2;
  localparam logic [1:0] ST_PULSE_LOW  = 2'd3;

  localparam logic [WIDTH_WORK-1:0] N_MIN_W   = WIDTH_WORK'(N_MIN);
  localparam logic [WIDTH_WORK-1:0] START_W   = WIDTH_WORK'(START_PERIOD);
  localparam logic [WIDTH_WORK-1:0] ACC_W     = WIDTH_WORK'(ACC_STEP);
  localparam logic [WIDTH_WORK-1:0] HI_LAST   = WIDTH_WORK'(PULSE_HI - 1);
  localparam logic [WIDTH_WORK-1:0] SETUP_LST = WIDTH_WORK'(DIR_SETUP - 1);
  localparam logic [WIDTH_WORK-1:0] ONE_W     = WIDTH_WORK'(1);

  logic [1:0]            state_q, state_d;
  logic [WIDTH_WORK-1:0] cnt_q, cnt_d;
  logic [WIDTH_WORK-1:0] cur_period_q, cur_period_d;
  logic [WIDTH_WORK-1:0] period_tgt_q, period_tgt_d;
  logic [WIDTH_WORK-1:0] step_cnt_q, step_cnt_d;
  logic                  drv_step_q, drv_step_d;
  logic                  drv_dir_q, drv_dir_d;
  logic                  busy_q, busy_d;
  logic [WIDTH_WORK-1:0] ramp_diff;
  logic [WIDTH_WORK-1:0] ramp_next;

  // Next-state logic: target latch, period ramp and step FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_period_d = cur_period_q;
    period_tgt_d = period_tgt_q;
    step_cnt_d   = step_cnt_q;
    drv_step_d   = drv_step_q;
    drv_dir_d    = drv_dir_q;
    ramp_diff    = '0;
    ramp_next    = cur_period_q;

    if (period_load) begin
      if (period_in == '0)          period_tgt_d = '0;
      else if (period_in < N_MIN_W) period_tgt_d = N_MIN_W;
      else                          period_tgt_d = period_in;
    end

    // Ramp uses the old target, so a load coinciding with a boundary waits a step.
    if (cur_period_q > period_tgt_q) begin
      ramp_diff = cur_period_q - period_tgt_q;
      ramp_next = (ramp_diff > ACC_W) ? (cur_period_q - ACC_W) : period_tgt_q;
    end else begin
      ramp_diff = period_tgt_q - cur_period_q;
      ramp_next = (ramp_diff > ACC_W) ? (cur_period_q + ACC_W) : period_tgt_q;
    end

    case (state_q)
      ST_IDLE: begin
        drv_step_d = 1'b0;
        if (enable && period_tgt_q != '0) begin
          cur_period_d = START_W;
          cnt_d        = '0;
          if (dir_req != drv_dir_q) begin
            drv_dir_d = dir_req;
            state_d   = ST_DIR_SETUP;
          end else begin
            drv_step_d = 1'b1;
            state_d    = ST_PULSE_HIGH;
          end
        end
      end
      ST_DIR_SETUP: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SETUP_LST) begin
          cnt_d      = '0;
          drv_step_d = 1'b1;
          state_d    = ST_PULSE_HIGH;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      ST_PULSE_HIGH: begin
        cnt_d = cnt_q + ONE_W;
        if (cnt_q == HI_LAST) begin
          drv_step_d = 1'b0;
          state_d    = ST_PULSE_LOW;
        end
      end
      default: begin // ST_PULSE_LOW: cnt keeps counting from the rise
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == cur_period_q - ONE_W) begin
          step_cnt_d = step_cnt_q + ONE_W;
          cnt_d      = '0;
          if (period_tgt_q != '0) cur_period_d = ramp_next;
          if (period_tgt_q == '0) begin
            state_d = ST_IDLE;
          end else if (dir_req != drv_dir_q) begin
            drv_dir_d    = dir_req;
            cur_period_d = START_W;
            state_d      = ST_DIR_SETUP;
          end else begin
            drv_step_d = 1'b1;
            state_d    = ST_PULSE_HIGH;
          end
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_period_q <= START_W;
      period_tgt_q <= '0;
      step_cnt_q   <= '0;
      drv_step_q   <= 1'b0;
      drv_dir_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_period_q <= cur_period_d;
      period_tgt_q <= period_tgt_d;
      step_cnt_q   <= step_cnt_d;
      drv_step_q   <= drv_step_d;
      drv_dir_q    <= drv_dir_d;
      busy_q       <= busy_d;
    end
  end

  assign drv_step = drv_step_q;
  assign drv_dir  = drv_dir_q;
  assign busy     = busy_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_sm_step_scheduler.sv
// Directed bench for sm_step_scheduler with small timing parameters.
module tb_sm_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        dir_req = 1'b0;
  logic [15:0] period_in = '0;
  logic        period_load = 1'b0;
  logic        drv_step, drv_dir, busy;
  logic [15:0] step_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sm_step_scheduler #(
    .WIDTH_WORK(16), .PULSE_HI(4), .DIR_SETUP(6), .N_MIN(10),
    .START_PERIOD(40), .ACC_STEP(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir_req(dir_req),
    .period_in(period_in), .period_load(period_load),
    .drv_step(drv_step), .drv_dir(drv_dir), .busy(busy), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] v);
    period_in   = v;
    period_load = 1'b1;
    @(negedge clk);
    period_load = 1'b0;
  endtask

  task automatic wait_rise(input string tag, output int c);
    int n = 0;
    while (drv_step !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(drv_step), 32'd1);
    c = cyc;
  endtask

  task automatic high_width(output int w);
    w = 0;
    while (drv_step === 1'b1 && w < 200) begin
      w++;
      @(negedge clk);
    end
  endtask

  initial begin
    int r[0:12];
    int w, cd, ci;
    int exp_p[1:5];
    int exp_q[8:12];
    exp_p = '{40, 32, 24, 16, 16};
    exp_q = '{32, 24, 16, 10, 10};

    // 1. reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enable      = i[0];
      dir_req     = ~i[1];
      period_in   = 16'd16;
      period_load = 1'b1;
    end
    @(negedge clk);
    chk("rst_step", 32'(drv_step), 0);
    chk("rst_dir",  32'(drv_dir),  0);
    chk("rst_busy", 32'(busy),     0);
    chk("rst_cnt",  32'(step_cnt), 0);
    enable = 1'b0; dir_req = 1'b0; period_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    // 2. ramp 40,32,24,16,16 with enable and no target yet
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_tgt_busy", 32'(busy), 0);
    load(16'd16);
    chk("lat_edge1", 32'(drv_step), 0);
    @(negedge clk);
    chk("lat_edge2", 32'(drv_step), 1);
    chk("run_busy", 32'(busy), 1);
    r[0] = cyc;
    for (int k = 1; k <= 5; k++) begin
      high_width(w);
      chk($sformatf("hi_width%0d", k), 32'(w), 4);
      wait_rise($sformatf("rise%0d", k), r[k]);
      chk($sformatf("period%0d", k), 32'(r[k] - r[k-1]), 32'(exp_p[k]));
    end
    chk("cnt_ramp", 32'(step_cnt), 5);

    // 3. direction change mid-run
    dir_req = 1'b1;
    begin
      int n = 0;
      while (drv_dir !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    cd = cyc;
    chk("dir_set", 32'(drv_dir), 1);
    chk("dir_at_boundary", 32'(cd - r[5]), 16);
    chk("dir_step_low", 32'(drv_step), 0);
    chk("dir_cnt", 32'(step_cnt), 6);
    wait_rise("rise6", r[6]);
    chk("dir_setup_gap", 32'(r[6] - cd), 6);
    high_width(w);
    wait_rise("rise7", r[7]);
    chk("period_after_dir", 32'(r[7] - r[6]), 40);
    chk("cnt_after_dir", 32'(step_cnt), 7);

    // 4. clamp 3 -> 10, then stop with 0
    load(16'd3);
    for (int k = 8; k <= 12; k++) begin
      high_width(w);
      wait_rise($sformatf("rise%0d", k), r[k]);
      chk($sformatf("period%0d", k), 32'(r[k] - r[k-1]), 32'(exp_q[k]));
    end
    load(16'd0);
    begin
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    ci = cyc;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_time", 32'(ci - r[12]), 10);
    chk("stop_cnt", 32'(step_cnt), 13);
    repeat (20) @(negedge clk);
    chk("stopped_step", 32'(drv_step), 0);
    chk("stopped_busy", 32'(busy), 0);

    // 5. disable at 2nd high cycle
    load(16'd16);
    @(negedge clk);
    chk("restart_rise", 32'(drv_step), 1);
    @(negedge clk);
    enable = 1'b0;
    high_width(w);
    chk("dis_hi_width", 32'(w + 1), 4);
    @(negedge clk);
    chk("dis_idle", 32'(busy), 0);
    chk("dis_cnt", 32'(step_cnt), 13);
    repeat (10) @(negedge clk);
    chk("dis_no_step", 32'(drv_step), 0);

    // 6. async reset mid-pulse
    enable = 1'b1;
    wait_rise("rise_pre_rst", ci);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_step", 32'(drv_step), 0);
    chk("arst_cnt",  32'(step_cnt), 0);
    chk("arst_busy", 32'(busy),     0);
    chk("arst_dir",  32'(drv_dir),  0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
